// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the reaction-game round
//               sequencer. Holds the round state encoding, the status codes
//               shown on display digit 2 and a small lives helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Round sequencer states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    MOVE     = 3'd2,
    WAIT_KEY = 3'd3,
    CHECK    = 3'd4,
    SHOW     = 3'd5,
    OVER     = 3'd6
  } state_e;

  // Status codes driven onto display digit 2.
  localparam logic [3:0] ST_IDLE = 4'hF;
  localparam logic [3:0] ST_PLAY = 4'h1;
  localparam logic [3:0] ST_HIT  = 4'hA;
  localparam logic [3:0] ST_MISS = 4'hE;
  localparam logic [3:0] ST_OVER = 4'h0;

  // Lives never go below zero, even if a miss is judged with none left.
  function automatic logic [3:0] lives_dec(input logic [3:0] lives);
    return (lives == 4'd0) ? 4'd0 : lives - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter2
// Description : Two-digit BCD score counter. Increments by one when inc_i is
//               high; the ones digit wraps 9->0 with a carry into the tens
//               digit, and the count saturates at 99 instead of wrapping.
//               clr_ni is a synchronous active-low clear.
// Ports       : clk     - system clock
//               clr_ni  - synchronous clear, active low (count -> 00)
//               inc_i   - add one this cycle
//               ones_o  - ones digit (BCD, registered)
//               tens_o  - tens digit (BCD, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter2 (
  input  logic       clk,
  input  logic       clr_ni,
  input  logic       inc_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       at_max;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    at_max = (ones_q == 4'd9) && (tens_q == 4'd9);
    if (inc_i && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_ni) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_round_ctrl
// Description : Round sequencer for the keypad/stepper reaction game. Each
//               round latches a target nibble from the LFSR, commands the
//               stepper to it, waits (with timeout) for a keypad press, judges
//               hit or miss, and keeps a BCD score and a lives count that are
//               shown on the four seven-segment digits.
// Ports       : clk          - system clock
//               reset        - synchronous reset, active low
//               start        - restart button level (rising edge starts game)
//               random       - LFSR nibble, sampled once per round
//               key_valid    - keypad press level
//               key_value    - keypad code, valid while key_valid=1
//               motor_busy   - stepper wrapper is moving
//               motor_go     - one-cycle move command
//               motor_target - target nibble for the stepper wrapper
//               in0 / in1    - score ones / tens (BCD)
//               in2          - status code
//               in3          - lives (combinational from the lives register)
//               round_active - high in MOVE and WAIT_KEY
// Revision    : 1.0 - initial release
// ============================================================================
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int SHOW_CYCLES    = 100_000_000,
  parameter int START_LIVES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] random,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       motor_busy,
  output logic       motor_go,
  output logic [3:0] motor_target,
  output logic [3:0] in0,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic [3:0] in3,
  output logic       round_active
);

  // One timer serves both the key timeout and the result display hold, so
  // it is sized for the longer of the two.
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_LAST    = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [3:0]         LIVES_INIT   = 4'(START_LIVES);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic                 start_prev_q;
  logic                 key_prev_q;
  logic [3:0]           target_q, target_d;
  logic [3:0]           key_cap_q, key_cap_d;
  logic                 key_got_q, key_got_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           lives_q, lives_d;
  logic                 motor_go_q, motor_go_d;
  logic [3:0]           motor_target_q, motor_target_d;
  logic [3:0]           in2_q, in2_d;
  logic                 round_active_q, round_active_d;

  // Score counter controls.
  logic                 score_inc;
  logic                 score_clr;

  // Rising edges: current input high, registered previous value low.
  logic                 start_rise;
  logic                 key_rise;
  logic                 hit;

  assign start_rise = start && !start_prev_q;
  assign key_rise   = key_valid && !key_prev_q;

  // A timeout leaves key_got_q clear, so it can never be judged a hit.
  assign hit = key_got_q && (key_cap_q == target_q);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    key_cap_d      = key_cap_q;
    key_got_d      = key_got_q;
    timer_d        = timer_q;
    lives_d        = lives_q;
    motor_go_d     = 1'b0;
    motor_target_d = motor_target_q;
    in2_d          = in2_q;
    score_inc      = 1'b0;
    score_clr      = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          lives_d   = LIVES_INIT;
          score_clr = 1'b1;
          in2_d     = ST_PLAY;
          state_d   = LATCH;
        end
      end

      LATCH: begin
        target_d       = random;
        motor_target_d = random;
        motor_go_d     = 1'b1;
        state_d        = MOVE;
      end

      MOVE: begin
        // motor_go is high during the first MOVE cycle; the wrapper cannot
        // have raised busy yet, so busy is only trusted after that cycle.
        if (!motor_go_q && !motor_busy) begin
          timer_d   = '0;
          key_got_d = 1'b0;
          state_d   = WAIT_KEY;
        end
      end

      WAIT_KEY: begin
        // The key is tested first so a press on the last allowed cycle
        // beats the timeout.
        if (key_rise) begin
          key_cap_d = key_value;
          key_got_d = 1'b1;
          state_d   = CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          key_got_d = 1'b0;
          state_d   = CHECK;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      CHECK: begin
        if (hit) begin
          score_inc = 1'b1;
          in2_d     = ST_HIT;
        end else begin
          lives_d = lives_dec(lives_q);
          in2_d   = ST_MISS;
        end
        timer_d = '0;
        state_d = SHOW;
      end

      SHOW: begin
        if (timer_q == SHOW_LAST) begin
          if (lives_q == 4'd0) begin
            in2_d   = ST_OVER;
            state_d = OVER;
          end else begin
            in2_d   = ST_PLAY;
            state_d = LATCH;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        in2_d   = ST_IDLE;
        state_d = IDLE;
      end
    endcase

    // Registered from the next state so the flag lines up with the state.
    round_active_d = (state_d == MOVE) || (state_d == WAIT_KEY);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b0;
      key_prev_q     <= 1'b0;
      target_q       <= 4'd0;
      key_cap_q      <= 4'd0;
      key_got_q      <= 1'b0;
      timer_q        <= '0;
      lives_q        <= LIVES_INIT;
      motor_go_q     <= 1'b0;
      motor_target_q <= 4'd0;
      in2_q          <= ST_IDLE;
      round_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start;
      key_prev_q     <= key_valid;
      target_q       <= target_d;
      key_cap_q      <= key_cap_d;
      key_got_q      <= key_got_d;
      timer_q        <= timer_d;
      lives_q        <= lives_d;
      motor_go_q     <= motor_go_d;
      motor_target_q <= motor_target_d;
      in2_q          <= in2_d;
      round_active_q <= round_active_d;
    end
  end

  // --------------------------------------------------------------------------
  // Score counter (cleared by reset or by a new game)
  // --------------------------------------------------------------------------
  logic score_clr_n;
  assign score_clr_n = reset && !score_clr;

  bcd_counter2 u_score (
    .clk    (clk),
    .clr_ni (score_clr_n),
    .inc_i  (score_inc),
    .ones_o (in0),
    .tens_o (in1)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign motor_go     = motor_go_q;
  assign motor_target = motor_target_q;
  assign in2          = in2_q;
  assign in3          = lives_q;
  assign round_active = round_active_q;

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_round_ctrl
// Description : Self-checking bench for game_round_ctrl. Plays randomized
//               rounds (random targets, motor busy lengths, key timing) and
//               compares the display, motor and status outputs against a
//               round-level score/lives model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_ctrl;

  localparam int TO = 20;
  localparam int SH = 5;
  localparam int SL = 3;

  localparam logic [3:0] C_IDLE = 4'hF;
  localparam logic [3:0] C_PLAY = 4'h1;
  localparam logic [3:0] C_HIT  = 4'hA;
  localparam logic [3:0] C_MISS = 4'hE;
  localparam logic [3:0] C_OVER = 4'h0;

  // Round kinds
  localparam int K_HIT        = 0;  // correct key before timeout
  localparam int K_WRONG      = 1;  // wrong key before timeout
  localparam int K_TIMEOUT    = 2;  // no key at all
  localparam int K_EDGE_HIT   = 3;  // correct key on the last allowed cycle
  localparam int K_MOVE_PRESS = 4;  // key pressed during MOVE and held
  localparam int K_HELD       = 5;  // key held over from the previous round

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] random = 4'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       motor_busy = 1'b0;
  logic       motor_go;
  logic [3:0] motor_target;
  logic [3:0] in0, in1, in2, in3;
  logic       round_active;

  game_round_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .SHOW_CYCLES    (SH),
    .START_LIVES    (SL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .random       (random),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .motor_busy   (motor_busy),
    .motor_go     (motor_go),
    .motor_target (motor_target),
    .in0          (in0),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .round_active (round_active)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_score;
  int         m_lives;
  logic [3:0] cur_tgt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, "_score"}, {24'd0, in1, in0}, {24'd0, to_bcd(m_score)});
    check_eq({tag, "_lives"}, {28'd0, in3}, m_lives);
  endtask

  task automatic wait_go();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (motor_go === 1'b1) ok = 1'b1;
      else step();
    end
    check_eq("motor_go_seen", {31'd0, ok}, 1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic play_round(input int kind, input int busy_n, input int key_j,
                            input bit hold_after, input bit poke_start);
    int         press_at;
    logic [3:0] press_val;
    bit         exp_hit;
    int         exp_lat;
    int         lat;
    int         show_len;
    logic [3:0] code;
    logic [3:0] tgt;

    tgt = cur_tgt;
    wait_go();
    check_eq("latch_target", motor_target, tgt);
    check_eq("play_code", in2, C_PLAY);
    check_eq("round_active_move", round_active, 1);
    check_model("round_start");
    step();
    check_eq("go_pulse_width", motor_go, 0);
    motor_busy = 1'b1;
    random     = 4'($urandom);   // LFSR keeps running; target must not follow
    for (int i = 2; i <= busy_n; i++) begin
      if (kind == K_MOVE_PRESS && i == 2) begin
        key_valid = 1'b1;
        key_value = tgt;
      end
      start = poke_start && (i == 2);
      step();
    end
    start      = 1'b0;
    motor_busy = 1'b0;
    step();                      // first WAIT_KEY cycle

    press_at  = -1;
    press_val = tgt;
    exp_hit   = 1'b0;
    exp_lat   = TO + 1;
    case (kind)
      K_HIT: begin
        press_at = key_j;
        exp_hit  = 1'b1;
        exp_lat  = key_j + 2;
      end
      K_WRONG: begin
        press_at  = key_j;
        press_val = tgt ^ 4'($urandom_range(1, 15));
        exp_lat   = key_j + 2;
      end
      K_EDGE_HIT: begin
        press_at = TO - 1;
        exp_hit  = 1'b1;
      end
      default: ;
    endcase

    lat = 0;
    while (in2 === C_PLAY && lat < TO + 20) begin
      if (lat == press_at) begin
        key_valid = 1'b1;
        key_value = press_val;
      end
      step();
      lat++;
    end
    check_eq("result_latency", lat, exp_lat);

    if (exp_hit) begin
      if (m_score < 99) m_score++;
      code = C_HIT;
    end else begin
      if (m_lives > 0) m_lives--;
      code = C_MISS;
    end
    check_eq("result_code", in2, code);
    check_eq("round_active_show", round_active, 0);
    check_model("result");

    cur_tgt = 4'($urandom);
    random  = cur_tgt;
    if (!hold_after) key_valid = 1'b0;

    show_len = 0;
    while (in2 === code && show_len < SH + 20) begin
      show_len++;
      step();
    end
    check_eq("show_len", show_len, SH);
    check_eq("after_show_code", in2, (m_lives == 0) ? C_OVER : C_PLAY);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit go_in_over;

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check_eq("rst_in2", in2, C_IDLE);
    check_eq("rst_in3", in3, SL);
    check_eq("rst_score", {in1, in0}, 8'h00);
    check_eq("rst_motor_go", motor_go, 0);
    check_eq("rst_motor_target", motor_target, 0);
    check_eq("rst_round_active", round_active, 0);
    reset = 1'b1;
    repeat (3) step();
    check_eq("idle_hold_in2", in2, C_IDLE);

    // Game 1: first round target 7, then a wrong key, then climb to 99
    m_score = 0;
    m_lives = SL;
    cur_tgt = 4'h7;
    random  = cur_tgt;
    start_pulse();
    play_round(K_HIT, 10, 3, 1'b0, 1'b0);
    cur_tgt = 4'h5;
    random  = cur_tgt;
    play_round(K_WRONG, 4, 2, 1'b0, 1'b1);
    for (int r = 0; r < 100; r++) begin
      play_round((r % 9 == 4) ? K_EDGE_HIT : K_HIT,
                 $urandom_range(3, 8), $urandom_range(0, TO - 2),
                 1'b0, ($urandom_range(0, 3) == 0));
    end
    play_round(K_HIT, 3, 1, 1'b1, 1'b0);
    play_round(K_HELD, 4, 0, 1'b0, 1'b0);
    play_round(K_MOVE_PRESS, 5, 0, 1'b0, 1'b0);

    // Game over: nothing moves, score held
    go_in_over = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (motor_go === 1'b1) go_in_over = 1'b1;
      step();
    end
    check_eq("over_no_go", {31'd0, go_in_over}, 0);
    check_eq("over_code", in2, C_OVER);
    check_model("over");

    // Game 2: three timeouts end the game
    cur_tgt = 4'($urandom);
    random  = cur_tgt;
    start_pulse();
    m_score = 0;
    m_lives = SL;
    play_round(K_TIMEOUT, 6, 0, 1'b0, 1'b1);
    play_round(K_TIMEOUT, 3, 0, 1'b0, 1'b0);
    play_round(K_TIMEOUT, 4, 0, 1'b0, 1'b0);
    check_eq("over2_code", in2, C_OVER);
    check_model("over2");

    // Game 3: one hit, then reset in the middle of WAIT_KEY
    cur_tgt = 4'($urandom);
    random  = cur_tgt;
    start_pulse();
    m_score = 0;
    m_lives = SL;
    play_round(K_HIT, 5, 6, 1'b0, 1'b0);
    wait_go();
    repeat (6) step();
    check_eq("wait_round_active", round_active, 1);
    reset = 1'b0;
    step();
    check_eq("midrst_in2", in2, C_IDLE);
    check_eq("midrst_round_active", round_active, 0);
    check_eq("midrst_score", {in1, in0}, 8'h00);
    check_eq("midrst_lives", in3, SL);
    check_eq("midrst_motor_target", motor_target, 0);
    reset = 1'b1;
    repeat (4) step();
    check_eq("post_rst_idle", in2, C_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the keypad/stepper reaction game.
- Each round it latches a target nibble from the LFSR, commands the stepper to point at the target, then waits for a keypad press with a timeout.
- It judges hit or miss, keeps a BCD score and a lives count, and drives the four seven-segment digit nibbles.
- Sits between keypad4X4, LFSR, steppermotor_wrapper and SevSeg_4digit in the top level, and replaces the ad-hoc case_statement glue.

Parameters:
- TIMEOUT_CYCLES, 200_000_000: clk cycles allowed for a key press after the motor finishes (2 s at 100 MHz).
- SHOW_CYCLES, 100_000_000: clk cycles the hit/miss result is held on the display.
- START_LIVES, 3: lives loaded at game start (1..9).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  level; rising edge starts a new game (restart button)
- random  in  4  LFSR output, sampled once per round
- key_valid  in  1  keypad press level, high while a key is held
- key_value  in  4  keypad code, valid while key_valid=1
- motor_busy  in  1  stepper wrapper moving
- motor_go  out  1  one-cycle move command
- motor_target  out  4  target nibble to the motor wrapper, stable while motor_busy=1
- in0  out  4  display digit 0: score ones (BCD)
- in1  out  4  display digit 1: score tens (BCD)
- in2  out  4  display digit 2: status code
- in3  out  4  display digit 3: lives
- round_active  out  1  high in MOVE and WAIT_KEY

Behaviour:
- Reset (reset=0 at a clk edge), applied synchronously and from any state:
  - state IDLE; score 00; lives START_LIVES.
  - motor_go=0; motor_target=0; round_active=0.
  - in2=0xF (idle code); all counters 0.
  - Edge detector registers are cleared.
- Edge detection:
  - start and key_valid are each registered once.
  - A rise is current=1 and previous=0.
  - Only rises are acted on; a held key never counts twice.
- States:
  - IDLE: on a start rise, load lives=START_LIVES, score=00, go to LATCH.
  - LATCH (1 cycle): target<=random, motor_target<=random, motor_go=1 for this cycle only, go to MOVE.
  - MOVE: wait for motor_busy=0, which is sampled from the cycle after motor_go. Key rises are ignored here. Then clear the timer and go to WAIT_KEY.
  - WAIT_KEY: the timer increments every cycle.
    - key_valid rise: capture key_value, go to CHECK.
    - Timer reaching TIMEOUT_CYCLES-1 without a key: treat as a miss, go to CHECK.
    - If the rise and the timeout land on the same cycle, the key wins.
  - CHECK (1 cycle):
    - Hit (captured key == target): BCD score +1, in2=0xA.
    - Miss: lives-1, in2=0xE.
    - Go to SHOW with the timer cleared.
  - SHOW: hold for SHOW_CYCLES. Then go to OVER if lives==0, else LATCH.
  - OVER: in2=0x0 and score held. A start rise restarts exactly as from IDLE.
- Score rules:
  - Two BCD digits; ones wrap 9->0 and carry into tens.
  - 99 saturates at 99; it does not wrap.
- Lives:
  - Never decrement below 0.
  - in3 reflects lives combinationally from the register.
- start rise in any state other than IDLE/OVER is ignored; mid-game restart is done by reset.
- in2 during LATCH/MOVE/WAIT_KEY = 0x1 (playing).
- All outputs are registered except in3.

Decomposition:
- Package game_pkg holds:
  - state enum typedef (IDLE, LATCH, MOVE, WAIT_KEY, CHECK, SHOW, OVER);
  - status code constants ST_IDLE=0xF, ST_PLAY=0x1, ST_HIT=0xA, ST_MISS=0xE, ST_OVER=0x0.
- One natural sub-module: bcd_counter2, a two-digit saturating BCD incrementer with sync active-low clear.
- Edge detectors and timer stay inline.

Test Plan (TIMEOUT_CYCLES=20, SHOW_CYCLES=5, START_LIVES=3):
- Reset, then start rise with random=0x7:
  - motor_go pulses one cycle with motor_target=0x7 in LATCH;
  - in2=0x1, in3=3, in1:in0=00.
- Motor busy for 10 cycles, then key 0x7 pressed:
  - CHECK gives score 01 and in2=0xA for 5 cycles;
  - next round's LATCH follows.
- Key 0x3 against target 0x5: lives 3->2, in2=0xE, score unchanged.
- No key for 20 cycles in WAIT_KEY: miss. Three consecutive timeouts give lives=0, OVER, in2=0x0. A start rise restarts with lives=3, score 00.
- Key held across rounds and key pressed during MOVE: no score change. Key rise and timeout on the same cycle: scored as a key press.
- Score preset to 09 then a hit gives 10. Hits at 99 keep 99. reset=0 asserted mid-WAIT_KEY returns IDLE with in2=0xF on the next edge.
